// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared encodings for the HI/LO multiply/divide unit
//
// Purpose: operation codes presented on op, FSM state encodings and a small
// decode helper used by mult_div_unit.
package mult_div_unit_pkg;

  // Operation codes on op (6 and 7 are reserved and ignored)
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step
//
// Purpose: shifts the next dividend bit (MSB of quo_i) into the partial
// remainder, subtracts the divisor when it fits and shifts the resulting
// quotient bit into the LSB of the quotient register.
// Ports:
//   rem_i     partial remainder in (always < divisor, or the dividend prefix when divisor is 0)
//   quo_i     quotient/dividend shift register in
//   divisor_i divisor magnitude
//   rem_o     partial remainder out
//   quo_o     quotient/dividend shift register out
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // One extra bit: the shifted remainder can exceed WIDTH bits before the subtract
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor_i};
  assign fits    = (shifted >= {1'b0, divisor_i});

  // After a successful subtract the result is below the divisor, so it fits WIDTH bits.
  // A zero divisor always fits, leaving an all-ones quotient and the dividend as remainder.
  assign rem_o = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle HI/LO multiply/divide unit for the MIPS datapath
//
// Purpose: executes MULT/MULTU/DIV/DIVU over WIDTH iterations plus one sign
// fix-up cycle, and MTHI/MTLO in a single edge. Exposes HI/LO for MFHI/MFLO.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    operation request, sampled on the rising edge (ignored while busy)
//   op       operation code (see mult_div_unit_pkg)
//   rs_data  operand A: multiplicand / dividend / MTHI-MTLO source
//   rt_data  operand B: multiplier / divisor
//   busy     operation in flight; PC holds and register write is masked
//   done     one-cycle pulse after HI/LO were updated by a mult/div
//   hi, lo   HI and LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV
  logic [WIDTH-1:0]   opa_q, opa_d;
  // MUL: {partial product high, multiplier shifting out}; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_lo_q, neg_lo_d;  // product / quotient must be negated
  logic               neg_hi_q, neg_hi_d;  // remainder takes the dividend's sign
  logic               div0_q, div0_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand sign flags and magnitudes at accept time
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;

  assign rs_neg = is_signed_op(op) & rs_data[WIDTH-1];
  assign rt_neg = is_signed_op(op) & rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign rt_mag = rt_neg ? (~rt_data + 1'b1) : rt_data;

  // Shift-add step: add the multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right by one (carry lands in the top bit).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  logic [WIDTH-1:0]   div_rem, div_quo;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i     (acc_q[WIDTH-1:0]),
    .divisor_i (opa_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // Sign-corrected results, consumed only in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = div0_q ? '1 :
                    (neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              state_d  = ST_MUL;
              cnt_d    = '0;
              opa_d    = rs_mag;
              acc_d    = {{WIDTH{1'b0}}, rt_mag};
              neg_lo_d = rs_neg ^ rt_neg;
              neg_hi_d = 1'b0;
              div0_d   = 1'b0;
              is_div_d = 1'b0;
            end
            MDU_DIV, MDU_DIVU: begin
              state_d  = ST_DIV;
              cnt_d    = '0;
              opa_d    = rt_mag;
              acc_d    = {{WIDTH{1'b0}}, rs_mag};
              neg_lo_d = rs_neg ^ rt_neg;
              neg_hi_d = rs_neg;
              div0_d   = (rt_data == '0);
              is_div_d = 1'b1;
            end
            MDU_MTHI: hi_d = rs_data;
            MDU_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = (state_q == ST_MUL) ? mul_next : {div_rem, div_quo};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [2:0]  op      = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model in plain 64-bit arithmetic; returns {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge,
  // with operands scrambled so late latching would be caught.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(negedge clock);
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_done(input string nm, input int exp_busy,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int          bc    = 0;
    int          guard = 0;
    bit          held  = 1'b1;
    logic [31:0] h0    = hi;
    logic [31:0] l0    = lo;
    while (done !== 1'b1 && guard < 200) begin
      if (busy === 1'b1) bc++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      guard++;
      @(negedge clock);
    end
    check({nm, " busy cycles"}, 64'(bc), 64'(exp_busy));
    check({nm, " done seen"}, {63'd0, done}, 64'd1);
    check({nm, " hi/lo held while busy"}, {63'd0, held}, 64'd1);
    check({nm, " busy low at done"}, {63'd0, busy}, 64'd0);
    check({nm, " hi"}, {32'd0, hi}, {32'd0, ehi});
    check({nm, " lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] h0, l0, a, b;
    logic [2:0]  o;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{3'd0, 32'd0,         32'h0001_2345, 32'd0,         32'd0};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[8] = '{3'd3, 32'd50,        32'd7,         32'd1,         32'd7};
    vecs[9] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), 33, vecs[i].ehi, vecs[i].elo);
      @(negedge clock);
      check($sformatf("vec%0d done one cycle", i), {63'd0, done}, 64'd0);
    end

    // Reserved op is ignored
    h0 = hi;
    l0 = lo;
    start   = 1'b1;
    op      = 3'd6;
    rs_data = 32'hCAFE_F00D;
    @(negedge clock);
    start = 1'b0;
    check("reserved busy", {63'd0, busy}, 64'd0);
    @(negedge clock);
    check("reserved done", {63'd0, done}, 64'd0);
    check("reserved hi/lo", {hi, lo}, {h0, l0});

    // MTHI then MTLO on consecutive edges
    start   = 1'b1;
    op      = 3'd4;
    rs_data = 32'h1234_5678;
    @(negedge clock);
    check("mthi hi", {32'd0, hi}, 64'h1234_5678);
    check("mthi busy/done", {62'd0, busy, done}, 64'd0);
    op      = 3'd5;
    rs_data = 32'h9ABC_DEF0;
    @(negedge clock);
    start = 1'b0;
    check("mtlo lo", {32'd0, lo}, 64'h9ABC_DEF0);
    check("mtlo hi kept", {32'd0, hi}, 64'h1234_5678);
    check("mtlo busy/done", {62'd0, busy, done}, 64'd0);

    // MTHI while a DIV is busy must be ignored
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clock);
    start   = 1'b1;
    op      = 3'd4;
    rs_data = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0;
    wait_done("div with mthi", 29, 32'd2, 32'd14);

    // Reset in the middle of a DIVU
    @(negedge clock);
    issue(3'd3, 32'd50, 32'd7);
    repeat (9) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midop reset busy", {63'd0, busy}, 64'd0);
    check("midop reset done", {63'd0, done}, 64'd0);
    check("midop reset hi/lo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post reset idle", {63'd0, busy}, 64'd0);
    issue(3'd3, 32'd50, 32'd7);
    wait_done("divu after reset", 33, 32'd1, 32'd7);

    // Back-to-back: next op started in the done cycle
    @(negedge clock);
    issue(3'd1, 32'd3, 32'd5);
    wait_done("b2b multu", 33, 32'd0, 32'd15);
    issue(3'd3, 32'd15, 32'd4);
    wait_done("b2b divu", 33, 32'd3, 32'd3);
    @(negedge clock);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      exp = model(o, a, b);
      issue(o, a, b);
      wait_done($sformatf("rand%0d op%0d a=%0h b=%0h", i, o, a, b), 33, exp[63:32], exp[31:0]);
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
